// File: rtl/counter_pkg.sv
// counter_pkg: shared width default, 16-bit count type and the all-ones helper
// used for wrap detection by counter_16bit.
package counter_pkg;

    localparam int unsigned COUNTER_DEFAULT_WIDTH = 16;

    typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count16_t;

    // True when the low `width` bits of `value` are all ones (width 1..32).
    function automatic logic is_all_ones(input logic [31:0] value, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value & mask) == mask;
    endfunction

endpackage

// File: rtl/counter_16bit_if.sv
// counter_16bit_if: bundles the counter outputs for whoever observes them.
// The wrap signal exists only when COUNTER_16BIT_WRAP_FLAG_EN is defined.
interface counter_16bit_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] count;
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
    logic             wrap;
`endif

    // The counter drives, consumers observe.
    modport master (
        output count
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
        , output wrap
`endif
    );

    modport slave (
        input count
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
        , input wrap
`endif
    );

endinterface

// File: rtl/counter_16bit.sv
// counter_16bit: free-running WIDTH-bit up-counter, async active-high clear to RST_VALUE,
// wraps modulo 2^WIDTH. Define COUNTER_16BIT_WRAP_FLAG_EN to add the o_wrap pulse output.
// Ports stay plain and in fixed order so positional instantiation keeps working.
module counter_16bit
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = COUNTER_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_async,
    output logic [WIDTH-1:0] o_count
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
    ,
    output logic             o_wrap
`endif
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: plain unsigned increment, carry out of the MSB is dropped.
    always_comb begin
        count_d = count_q + WIDTH'(1);
    end

    // Count register; reset clears immediately and wins over a coincident clock edge.
    always_ff @(posedge i_clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            count_q <= RST_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

`ifdef COUNTER_16BIT_WRAP_FLAG_EN
    // running_q is low until the first edge after reset, so the release edge never flags
    // a wrap even when RST_VALUE is all ones.
    logic running_q, running_d;
    logic wrap_q, wrap_d;

    // Wrap pulse is registered alongside the all-ones -> zero transition of the count.
    always_comb begin
        running_d = 1'b1;
        wrap_d    = running_q && is_all_ones(32'(count_q), WIDTH);
    end

    // Wrap-flag registers, cleared with the counter.
    always_ff @(posedge i_clk or posedge i_rst_async) begin
        if (i_rst_async) begin
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_counter_16bit.sv
// tb_counter_16bit: scoreboard bench for counter_16bit. Three instances share clock and reset:
// WIDTH=16/RST_VALUE=0, WIDTH=4, and WIDTH=16/RST_VALUE=16'hFFF0. The reference model only
// tracks "in reset" and "edges since release" and derives every expected value from those.
`timescale 1ns/1ps
module tb_counter_16bit;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    counter_16bit_if #(.WIDTH(16)) bus16 ();
    counter_16bit_if #(.WIDTH(4))  bus4 ();
    counter_16bit_if #(.WIDTH(16)) busff ();

    counter_16bit #(.WIDTH(16), .RST_VALUE(16'h0000)) u_dut16 (
        .i_clk       (clk),
        .i_rst_async (rst),
        .o_count     (bus16.count)
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
        , .o_wrap    (bus16.wrap)
`endif
    );

    counter_16bit #(.WIDTH(4), .RST_VALUE(4'h0)) u_dut4 (
        .i_clk       (clk),
        .i_rst_async (rst),
        .o_count     (bus4.count)
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
        , .o_wrap    (bus4.wrap)
`endif
    );

    counter_16bit #(.WIDTH(16), .RST_VALUE(16'hFFF0)) u_dutff (
        .i_clk       (clk),
        .i_rst_async (rst),
        .o_count     (busff.count)
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
        , .o_wrap    (busff.wrap)
`endif
    );

    typedef struct {
        count16_t   c16;
        logic [3:0] c4;
        count16_t   cff;
        logic       w16;
        logic       w4;
        logic       wff;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit          in_reset = 1'b1;
    int unsigned n        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%h, expected 0x%h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t expect_now();
        exp_t        e;
        int unsigned v16, v4, vff;
        v16   = in_reset ? 0 : n % 65536;
        v4    = in_reset ? 0 : n % 16;
        vff   = (32'hFFF0 + (in_reset ? 0 : n)) % 65536;
        e.c16 = 16'(v16);
        e.c4  = 4'(v4);
        e.cff = 16'(vff);
        // A wrap is a count reaching zero by counting, never on the release edge.
        e.w16 = !in_reset && n >= 2 && v16 == 0;
        e.w4  = !in_reset && n >= 2 && v4 == 0;
        e.wff = !in_reset && n >= 2 && vff == 0;
        return e;
    endfunction

    // Account for one rising edge given the reset level held across it.
    task automatic model_edge();
        if (in_reset) n = 0;
        else n++;
    endtask

    task automatic model_rst(input bit r);
        if (r) begin
            in_reset = 1'b1;
            n        = 0;
        end else begin
            in_reset = 1'b0;
        end
    endtask

    task automatic push();
        sb_q.push_back(expect_now());
    endtask

    // One clock: after the edge, drive reset for the next edge and queue the expectation.
    task automatic step(input bit r);
        @(posedge clk);
        #2;
        model_edge();
        rst = r;
        model_rst(r);
        push();
    endtask

    // Monitor: the counter presents a value every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("count16", 32'(bus16.count), 32'(e.c16));
                check("count4", 32'(bus4.count), 32'(e.c4));
                check("count_rstff0", 32'(busff.count), 32'(e.cff));
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
                check("wrap16", 32'(bus16.wrap), 32'(e.w16));
                check("wrap4", 32'(bus4.wrap), 32'(e.w4));
                check("wrap_rstff0", 32'(busff.wrap), 32'(e.wff));
`endif
            end
        end
    end

    // Stimulus.
    initial begin
        // Reset held across 50 edges.
        repeat (50) step(1'b1);
        step(1'b0);

        // 100 edges after release.
        repeat (100) step(1'b0);
        #1 check("after_100_edges", 32'(bus16.count), 32'd100);

        // Continue to all-ones, then wrap.
        repeat (65435) step(1'b0);
        #1 check("at_ffff", 32'(bus16.count), 32'h0000_FFFF);
        step(1'b0);
        #1 check("wrap_to_zero", 32'(bus16.count), 32'h0);
`ifdef COUNTER_16BIT_WRAP_FLAG_EN
        check("wrap_pulse", 32'(bus16.wrap), 32'h1);
`endif
        repeat (3) step(1'b0);

        // Random reset activity.
        repeat (3000) step($urandom_range(0, 15) == 0);

        // Short reset pulse at 0x1234, clearing between edges.
        step(1'b1);
        step(1'b0);
        repeat (16'h1233) step(1'b0);
        @(posedge clk);
        #1;
        model_edge();
        check("pre_pulse_1234", 32'(bus16.count), 32'h0000_1234);
        rst = 1'b1;
        #1;
        check("pulse_clears_now", 32'(bus16.count), 32'h0);
        model_rst(1'b1);
        push();
        @(posedge clk);
        #3;
        model_edge();
        rst = 1'b0;
        model_rst(1'b0);
        push();
        step(1'b0);
        #1 check("first_after_pulse", 32'(bus16.count), 32'h1);

        // Reset asserted on the same edge that would take 0x00FF to 0x0100.
        repeat (254) step(1'b0);
        #1 check("pre_coincident_00ff", 32'(bus16.count), 32'h0000_00FF);
        @(posedge clk);
        rst = 1'b1;
        model_rst(1'b1);
        #2;
        check("coincident_reset", 32'(bus16.count), 32'h0);
        push();
        step(1'b0);
        repeat (20) step(1'b0);

        // Let the monitor consume the last expectation.
        @(negedge clk);
        #1 check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
